// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential multiplier.
//   state_t : FSM state encoding (IDLE, BUSY, DONE)
//   clog2   : counter width for an iteration count (never less than 1 bit)
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mul_addsub.sv
// Combinational W-bit adder/subtractor used as the multiplier's single datapath adder.
// Ports:
//   a   : minuend / first addend
//   b   : subtrahend / second addend
//   sub : 1 selects a - b, 0 selects a + b
//   y   : result, W bits, wraps modulo 2^W
module seq_mul_addsub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    always_comb begin
        y = sub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential shift-add multiplier with valid/ready handshakes.
// One multiplier bit is retired per cycle; the product appears N cycles after
// the operands are accepted and is held until the consumer takes it.
// Optional build macro SEQ_MUL_SIGNED_EN adds the tc port for two's complement
// operands; without it the block is unsigned only.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : operands A/B (and tc) present
//   in_ready  : operands can be accepted this cycle
//   A         : multiplicand, M bits
//   B         : multiplier, N bits
//   out_valid : product P valid
//   out_ready : consumer takes P this cycle
//   P         : product, M+N bits, zero while out_valid is low
//   tc        : (SEQ_MUL_SIGNED_EN only) operands are two's complement
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M+N-1:0] P
`ifdef SEQ_MUL_SIGNED_EN
    ,
    input  logic           tc
`endif
);

    localparam int CNT_W = clog2(N);
    localparam int W     = M + 1;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [M-1:0]     a_q;
    logic             tc_q;
    // acc = {hi (M+1 bits), lo (N bits)}; lo starts as B and is consumed LSB first
    logic [M+N:0]     acc;
    logic [M+N-1:0]   p_q;

    logic [W-1:0]     opa;
    logic [W-1:0]     addend;
    logic [W-1:0]     sum;
    logic             last;
    logic             sub;
    logic             fill;
    logic [M+N:0]     acc_next;

    always_comb begin
        last     = (count == CNT_W'(N - 1));
        opa      = tc_q ? {a_q[M-1], a_q} : {1'b0, a_q};
        addend   = acc[0] ? opa : '0;
        // Signed B carries weight -2^(N-1) on its top bit, so that step subtracts.
        sub      = tc_q && last && acc[0];
        // Unsigned: the adder carry lands in sum[W-1], so shift in zero above it.
        // Signed: the (M+1)-bit sum cannot overflow, so extend its sign.
        fill     = tc_q ? sum[W-1] : 1'b0;
        acc_next = {fill, sum, acc[N-1:1]};
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    end

    seq_mul_addsub #(.W(W)) u_addsub (
        .a   (acc[M+N:N]),
        .b   (addend),
        .sub (sub),
        .y   (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            a_q       <= '0;
            tc_q      <= 1'b0;
            acc       <= '0;
            p_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= BUSY;
                        count <= '0;
                        a_q   <= A;
                        acc   <= {{(M+1){1'b0}}, B};
`ifdef SEQ_MUL_SIGNED_EN
                        tc_q  <= tc;
`else
                        tc_q  <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        p_q       <= acc_next[M+N-1:0];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        p_q       <= '0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        // Retire and accept on the same edge: no idle bubble.
                        if (in_valid) begin
                            state <= BUSY;
                            count <= '0;
                            a_q   <= A;
                            acc   <= {{(M+1){1'b0}}, B};
`ifdef SEQ_MUL_SIGNED_EN
                            tc_q  <= tc;
`else
                            tc_q  <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    p_q       <= '0;
                end
            endcase
        end
    end

    assign P = p_q;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter M, default 4: width of multiplicand A; legal range 2..32.
REQ-002 Parameter N, default 4: width of multiplier B and number of iteration cycles; legal range 2..32.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operands A/B present.
REQ-006 in_ready  output  1  block can accept operands this cycle.
REQ-007 A  input  M  multiplicand.
REQ-008 B  input  N  multiplier.
REQ-009 out_valid  output  1  product P valid.
REQ-010 out_ready  input  1  consumer takes P this cycle.
REQ-011 P  output  M+N  product.
REQ-012 tc  input  1  operands are two's complement; port exists only when SEQ_MUL_SIGNED_EN is defined.

Function
REQ-013 Radix-2 shift-add engine; one partial product (A AND B[i]) added per cycle; one (M+1)-bit adder; no combinational path from any input to P.
REQ-014 States: IDLE, BUSY, DONE.
REQ-015 in_ready = 1 in IDLE, and in DONE only while out_ready = 1; otherwise 0.
REQ-016 Accept: in_valid && in_ready on an edge; capture A, B (and tc); clear accumulator; load count = 0; go to BUSY.
REQ-017 BUSY: each edge processes bit count of B; adds A to the upper accumulator half when the bit is 1; shifts right one place; increments count.
REQ-018 On the edge processing bit N-1, go to DONE; out_valid rises exactly N edges after the accepting edge.
REQ-019 DONE: out_valid = 1; P and out_valid held stable until out_ready = 1 (indefinite backpressure).
REQ-020 DONE && out_ready && !in_valid: next state IDLE; out_valid drops.
REQ-021 DONE && out_ready && in_valid: result retires and new operands are accepted on the same edge; next state BUSY; no idle bubble.
REQ-022 in_valid during BUSY is ignored; operands are not captured; A/B may change freely.
REQ-023 Unsigned result: P = A*B exact, full M+N bits, no truncation or overflow.
REQ-024 P reads zero whenever out_valid = 0.

Reset
REQ-025 rst_n = 0 on an edge: state IDLE; out_valid 0; in_ready 1 (after the edge); P 0; count 0; accumulator 0.
REQ-026 Reset mid-BUSY or in DONE aborts the operation; the pending product is discarded and never presented.
REQ-027 in_valid is ignored on any edge where rst_n = 0.

Configuration
REQ-028 Macro SEQ_MUL_SIGNED_EN.
  - Defined: tc port present and sampled at accept. tc = 1: A sign-extended into the adder; bit N-1 step subtracts A (two's complement B); P is the signed product in M+N bits. tc = 0: behaviour per REQ-023.
  - Undefined: no tc port; unsigned only.
  - Latency and handshake are identical in both builds.

Structure
REQ-029 Shared package seq_mul_pkg holds the state encoding (IDLE/BUSY/DONE) and the count-width constant function clog2.
REQ-030 Sub-module seq_mul_addsub: (M+1)-bit add/subtract with sub select, purely combinational; instantiated once.
REQ-031 Top level contains the FSM, counter, operand registers and accumulator only.

Verification (M=4, N=4)
REQ-032 Unsigned: A=13, B=11 accepted at edge 0 -> out_valid at edge 4, P=8'h8F; max case A=15, B=15 -> P=8'hE1.
REQ-033 Zero operand: A=0, B=9 -> P=0 after 4 cycles; A=9, B=0 -> P=0.
REQ-034 Backpressure and throughput:
  - out_ready held 0 for 10 cycles -> P and out_valid stable; in_ready 0.
  - out_ready=1 with in_valid=1 (A=3, B=5) -> same-edge accept; P=15 after 4 more edges.
REQ-035 Reset: rst_n low for one edge at BUSY cycle 2 -> IDLE, out_valid 0, P 0, in_ready 1; the aborted product never appears.
REQ-036 SEQ_MUL_SIGNED_EN defined:
  - tc=1, A=-8 (4'h8), B=7 -> P=8'hC8 (-56).
  - tc=1, A=-1, B=-1 -> P=8'h01.
  - tc=0, A=4'h8, B=7 -> P=8'h38.
